// File: rtl/vga_frame_crc.sv
// Passive VGA tap: recovers the active window from the sync edges and publishes a
// per-frame CRC-32 of the active pixels over a pipelined Wishbone slave.
module vga_frame_crc #(
    parameter int unsigned CLKS_PER_PIXEL  = 2,
    parameter int unsigned H_START         = 96,
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned V_START         = 33,
    parameter int unsigned V_ACTIVE        = 480,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  vga_r,
    input  logic [3:0]  vga_g,
    input  logic [3:0]  vga_b,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic [1:0]  wb_adr,
    input  logic [31:0] wb_dat_w,
    output logic [31:0] wb_dat_r,
    input  logic [3:0]  wb_sel,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    output logic        wb_stall,
    output logic        wb_ack,
    output logic        wb_err
);

    localparam logic [15:0] L_H_START = 16'(H_START);
    localparam logic [15:0] L_CPP     = 16'(CLKS_PER_PIXEL);
    localparam logic [15:0] L_H_SPAN  = 16'(CLKS_PER_PIXEL * H_ACTIVE);
    localparam logic [15:0] L_V_START = 16'(V_START);
    localparam logic [15:0] L_V_END   = 16'(V_START + V_ACTIVE);
    localparam logic [31:0] CRC_POLY  = 32'h04C1_1DB7;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE} state_t;

    state_t      r_state, w_state_nxt;
    logic [11:0] r_rgb;
    logic        r_hs, r_vs, r_hs_d, r_vs_d;
    logic [15:0] r_line, r_cnt;
    logic [31:0] r_crc_run, r_pix_run;
    logic [31:0] r_crc_lat, r_pix_lat, r_frames;
    logic        r_enable, r_done, r_ovf;
    logic        r_ack;
    logic [31:0] r_dat;

    logic        w_hs_on, w_hs_on_d, w_vs_on, w_vs_on_d;
    logic        w_hs_deassert, w_vs_deassert, w_vs_assert;
    logic [15:0] w_hoff;
    logic        w_line_act, w_sample, w_take;
    logic [31:0] w_crc_nxt, w_crc_fin, w_pix_fin;
    logic        w_clr_run, w_complete;
    logic        w_req, w_wr_ctrl;
    logic [31:0] w_rd_mux;
    logic        w_unused;

    function automatic logic [31:0] f_crc12(input logic [31:0] crc, input logic [11:0] data);
        logic [31:0] c;
        logic [11:0] d;
        c = crc;
        d = data;
        for (int unsigned i = 0; i < 12; i++) begin
            if (c[31] ^ d[11]) c = {c[30:0], 1'b0} ^ CRC_POLY;
            else               c = {c[30:0], 1'b0};
            d = {d[10:0], 1'b0};
        end
        return c;
    endfunction

    // XOR with the polarity bit yields 1 whenever the sync is asserted
    assign w_hs_on       = r_hs ^ SYNC_ACTIVE_LOW;
    assign w_hs_on_d     = r_hs_d ^ SYNC_ACTIVE_LOW;
    assign w_vs_on       = r_vs ^ SYNC_ACTIVE_LOW;
    assign w_vs_on_d     = r_vs_d ^ SYNC_ACTIVE_LOW;
    assign w_hs_deassert = w_hs_on_d & ~w_hs_on;
    assign w_vs_deassert = w_vs_on_d & ~w_vs_on;
    assign w_vs_assert   = ~w_vs_on_d & w_vs_on;

    assign w_hoff     = r_cnt - L_H_START;
    assign w_line_act = (r_line >= L_V_START) && (r_line < L_V_END);
    assign w_sample   = w_line_act && (r_cnt >= L_H_START) &&
                        ((w_hoff % L_CPP) == '0) && (w_hoff < L_H_SPAN);
    assign w_take     = w_sample && (r_state == S_CAPTURE);
    assign w_crc_nxt  = f_crc12(r_crc_run, r_rgb);
    assign w_crc_fin  = w_take ? w_crc_nxt : r_crc_run;
    assign w_pix_fin  = w_take ? r_pix_run + 32'd1 : r_pix_run;

    assign w_req     = wb_cyc & wb_stb;
    assign w_wr_ctrl = w_req & wb_we & (wb_adr == 2'd0) & wb_sel[0];
    assign w_unused  = ^{wb_sel[3:1], wb_dat_w[31:3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb  <= '0;
            r_hs   <= 1'b0;
            r_vs   <= 1'b0;
            r_hs_d <= 1'b0;
            r_vs_d <= 1'b0;
            r_line <= '0;
            r_cnt  <= '0;
        end else begin
            r_rgb  <= {vga_r, vga_g, vga_b};
            r_hs   <= vga_hsync;
            r_vs   <= vga_vsync;
            r_hs_d <= r_hs;
            r_vs_d <= r_vs;
            if (w_vs_deassert)                r_line <= '0;
            else if (w_hs_deassert && r_line != '1) r_line <= r_line + 16'd1;
            if (w_hs_deassert)     r_cnt <= '0;
            else if (r_cnt != '1)  r_cnt <= r_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr_run   = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_enable) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (!r_enable) begin
                    w_state_nxt = S_IDLE;
                end else if (w_vs_assert) begin
                    w_state_nxt = S_CAPTURE;
                    w_clr_run   = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (!r_enable) begin
                    w_state_nxt = S_IDLE;
                end else if (w_vs_assert) begin
                    w_complete = 1'b1;
                    w_clr_run  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc_run <= '1;
            r_pix_run <= '0;
            r_crc_lat <= '1;
            r_pix_lat <= '0;
            r_frames  <= '0;
        end else begin
            if (w_clr_run) begin
                r_crc_run <= '1;
                r_pix_run <= '0;
            end else if (w_take) begin
                r_crc_run <= w_crc_nxt;
                r_pix_run <= r_pix_run + 32'd1;
            end
            if (w_complete) begin
                r_crc_lat <= w_crc_fin;
                r_pix_lat <= w_pix_fin;
                r_frames  <= r_frames + 32'd1;
            end
        end
    end

    // Frame completion is applied after the W1C so a same-cycle set wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_enable <= wb_dat_w[0];
            if (w_wr_ctrl && wb_dat_w[1]) r_done <= 1'b0;
            if (w_wr_ctrl && wb_dat_w[2]) r_ovf  <= 1'b0;
            if (w_complete) begin
                r_done <= 1'b1;
                if (r_done) r_ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (wb_adr)
            2'd0:    w_rd_mux = {29'd0, r_ovf, r_done, r_enable};
            2'd1:    w_rd_mux = r_crc_lat;
            2'd2:    w_rd_mux = r_frames;
            default: w_rd_mux = r_pix_lat;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req;
            if (w_req) r_dat <= w_rd_mux;
        end
    end

    assign wb_ack   = r_ack;
    assign wb_dat_r = r_dat;
    assign wb_stall = 1'b0;
    assign wb_err   = 1'b0;

endmodule

// File: tb/tb_vga_frame_crc.sv
// Directed bench for vga_frame_crc: small 4x2 active window, bench-side CRC model.
module tb_vga_frame_crc;

    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    logic        clk;
    logic        rst_n;
    logic [11:0] tb_rgb;
    logic        tb_hs, tb_vs;
    logic [1:0]  wb_adr;
    logic [31:0] wb_dat_w, wb_dat_r;
    logic [3:0]  wb_sel;
    logic        wb_cyc, wb_stb, wb_we;
    logic        wb_stall, wb_ack, wb_err;

    int checks   = 0;
    int failures = 0;
    logic [11:0] tb_pix [0:7];
    logic [31:0] rd, crc_ones, crc_flip;

    vga_frame_crc #(
        .CLKS_PER_PIXEL (2),
        .H_START        (2),
        .H_ACTIVE       (4),
        .V_START        (1),
        .V_ACTIVE       (2),
        .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vga_r    (tb_rgb[11:8]),
        .vga_g    (tb_rgb[7:4]),
        .vga_b    (tb_rgb[3:0]),
        .vga_hsync(tb_hs),
        .vga_vsync(tb_vs),
        .wb_adr   (wb_adr),
        .wb_dat_w (wb_dat_w),
        .wb_dat_r (wb_dat_r),
        .wb_sel   (wb_sel),
        .wb_cyc   (wb_cyc),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_stall (wb_stall),
        .wb_ack   (wb_ack),
        .wb_err   (wb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ne(input string tag, input logic [31:0] obs, input logic [31:0] bad);
        checks++;
        assert (obs !== bad) else begin
            failures++;
            $error("FAIL %s: observed=%h expected anything but %h", tag, obs, bad);
        end
    endtask

    // CRC-32 model: fold the 12-bit word into the top bits, then clock it out
    function automatic logic [31:0] model_frame();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int p = 0; p < 8; p++) begin
            c = c ^ {tb_pix[p], 20'd0};
            for (int b = 0; b < 12; b++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
        end
        return c;
    endfunction

    task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                           output logic [31:0] data_out);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_w = dat; wb_sel = 4'hF;
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        chk("ack", {31'd0, wb_ack}, 32'd1);
        data_out = wb_dat_r;
    endtask

    task automatic wr_ctrl(input logic [31:0] val);
        logic [31:0] dummy;
        wb_xfer(1'b1, 2'd0, val, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] adr, input logic [31:0] exp);
        logic [31:0] v;
        wb_xfer(1'b0, adr, 32'd0, v);
        chk(tag, v, exp);
    endtask

    // 4 clocks vsync off, nlines x (12 hsync-off + 4 hsync-on), 4 clocks vsync on.
    // Pixel p of active line l is held on steps 3+2p..4+2p so the DUT samples it.
    task automatic vga_frame(input int nlines);
        int total;
        int l;
        int j;
        total = 8 + 16 * nlines;
        for (int s = 0; s < total; s++) begin
            @(negedge clk);
            if (s < 4) begin
                tb_vs = 1'b1; tb_hs = 1'b0; tb_rgb = 12'h000;
            end else if (s < 4 + 16 * nlines) begin
                l = (s - 4) / 16;
                j = (s - 4) % 16;
                tb_vs = 1'b1;
                tb_hs = (j < 12);
                if (l < 2 && j >= 3 && j <= 10) tb_rgb = tb_pix[l * 4 + (j - 3) / 2];
                else if (j < 12)                tb_rgb = 12'h5A5;
                else                            tb_rgb = 12'h000;
            end else begin
                tb_vs = 1'b0; tb_hs = 1'b0; tb_rgb = 12'h000;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tb_rgb = '0; tb_hs = 1'b0; tb_vs = 1'b0;
        wb_adr = '0; wb_dat_w = '0; wb_sel = '0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        for (int p = 0; p < 8; p++) tb_pix[p] = 12'hFFF;
        crc_ones = model_frame();
        tb_pix[5] = 12'hFFE;
        crc_flip = model_frame();
        tb_pix[5] = 12'hFFF;

        // reset / idle
        repeat (3) @(negedge clk);
        chk("rst_dat_r", wb_dat_r, 32'd0);
        chk("rst_ack", {31'd0, wb_ack}, 32'd0);
        chk("rst_stall_err", {30'd0, wb_stall, wb_err}, 32'd0);
        rst_n = 1'b1;
        rd_chk("rst_ctrl", 2'd0, 32'h0);
        rd_chk("rst_crc", 2'd1, 32'hFFFF_FFFF);
        rd_chk("rst_fc", 2'd2, 32'd0);
        rd_chk("rst_pc", 2'd3, 32'd0);

        // single frame, then identical frame with DONE left set
        wr_ctrl(32'h1);
        rd_chk("en_ctrl", 2'd0, 32'h1);
        vga_frame(3);
        vga_frame(3);
        rd_chk("f1_ctrl", 2'd0, 32'h3);
        rd_chk("f1_crc", 2'd1, crc_ones);
        rd_chk("f1_fc", 2'd2, 32'd1);
        rd_chk("f1_pc", 2'd3, 32'd8);
        vga_frame(3);
        rd_chk("f2_crc", 2'd1, crc_ones);
        rd_chk("f2_fc", 2'd2, 32'd2);
        rd_chk("ovf_ctrl", 2'd0, 32'h7);
        wr_ctrl(32'h7);
        rd_chk("w1c_ctrl", 2'd0, 32'h1);

        // sensitivity to one pixel bit, then restore
        tb_pix[5] = 12'hFFE;
        vga_frame(3);
        wb_xfer(1'b0, 2'd1, 32'd0, rd);
        chk("flip_crc", rd, crc_flip);
        chk_ne("flip_differs", rd, crc_ones);
        rd_chk("flip_pc", 2'd3, 32'd8);
        rd_chk("flip_fc", 2'd2, 32'd3);
        rd_chk("flip_ctrl", 2'd0, 32'h3);
        tb_pix[5] = 12'hFFF;
        vga_frame(3);
        rd_chk("restore_crc", 2'd1, crc_ones);
        rd_chk("restore_ctrl", 2'd0, 32'h7);
        wr_ctrl(32'h7);

        // W1C landing in the frame-completion cycle: set wins
        fork
            vga_frame(3);
            begin
                repeat (53) @(negedge clk);
                wr_ctrl(32'h3);
            end
        join
        rd_chk("coll1_ctrl", 2'd0, 32'h3);
        rd_chk("coll1_fc", 2'd2, 32'd5);
        fork
            vga_frame(3);
            begin
                repeat (53) @(negedge clk);
                wr_ctrl(32'h3);
            end
        join
        rd_chk("coll2_ctrl", 2'd0, 32'h7);
        rd_chk("coll2_fc", 2'd2, 32'd6);

        // disable mid-frame discards the partial frame
        fork
            vga_frame(3);
            begin
                repeat (20) @(negedge clk);
                wr_ctrl(32'h0);
            end
        join
        rd_chk("dis_fc", 2'd2, 32'd6);
        rd_chk("dis_ctrl", 2'd0, 32'h6);
        wr_ctrl(32'h7);
        rd_chk("reen_ctrl", 2'd0, 32'h1);
        vga_frame(3);
        rd_chk("reen_fc_armed", 2'd2, 32'd6);
        vga_frame(3);
        rd_chk("reen_fc", 2'd2, 32'd7);
        rd_chk("reen_pc", 2'd3, 32'd8);
        rd_chk("reen_crc", 2'd1, crc_ones);

        // frame with no lines: nothing falls inside the active window
        vga_frame(0);
        rd_chk("blank_pc", 2'd3, 32'd0);
        rd_chk("blank_crc", 2'd1, 32'hFFFF_FFFF);
        rd_chk("blank_fc", 2'd2, 32'd8);
        rd_chk("blank_ctrl", 2'd0, 32'h7);

        // back-to-back reads
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 2'd1; wb_sel = 4'hF;
        @(negedge clk);
        wb_adr = 2'd3;
        chk("b2b_ack0", {31'd0, wb_ack}, 32'd1);
        chk("b2b_dat0", wb_dat_r, 32'hFFFF_FFFF);
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        chk("b2b_ack1", {31'd0, wb_ack}, 32'd1);
        chk("b2b_dat1", wb_dat_r, 32'd0);
        @(negedge clk);
        chk("b2b_ack_drop", {31'd0, wb_ack}, 32'd0);

        // asynchronous reset in the middle of a frame
        fork
            vga_frame(3);
            begin
                repeat (10) @(negedge clk);
                rd_chk("pre_rst_fc", 2'd2, 32'd8);
                repeat (8) @(negedge clk);
                rst_n = 1'b0;
                #1;
                chk("mid_rst_dat_r", wb_dat_r, 32'd0);
                chk("mid_rst_ack", {31'd0, wb_ack}, 32'd0);
                chk("mid_rst_stall_err", {30'd0, wb_stall, wb_err}, 32'd0);
            end
        join
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("post_rst_ctrl", 2'd0, 32'h0);
        rd_chk("post_rst_crc", 2'd1, 32'hFFFF_FFFF);
        rd_chk("post_rst_fc", 2'd2, 32'd0);
        rd_chk("post_rst_pc", 2'd3, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_frame_crc.md
# vga_frame_crc

Passive checker that sits directly downstream of the VERA video output in the test SoC. It taps vga_r/g/b/hsync/vsync on sys_clk, recovers the active-pixel window from the sync edges, and computes a CRC-32 over every active pixel of each frame. It publishes the frame CRC, pixel count and frame count on a 32-bit pipelined Wishbone slave, so software and testbenches can check rendering without a screen.

## Interface
- CLKS_PER_PIXEL, 2: sys_clk cycles per pixel (VERA 25 MHz pixel rate on 50 MHz sys_clk).
- H_START, 96: clocks from the hsync-deassert edge to the first active pixel sample.
- H_ACTIVE, 640: active pixels per line.
- V_START, 33: line index of the first active line.
- V_ACTIVE, 480: active lines per frame.
- SYNC_ACTIVE_LOW, 1: 1 means hsync/vsync are asserted when low.

Ports:
- clk  in  1  sys_clk; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- vga_r / vga_g / vga_b  in  4 each  pixel colour from VERA.
- vga_hsync, vga_vsync  in  1  sync signals from VERA.
- wb_adr  in  2  word address (bus adr[3:2]).
- wb_dat_w  in  32  write data.
- wb_dat_r  out  32  read data.
- wb_sel  in  4  byte enables.
- wb_cyc, wb_stb, wb_we  in  1  Wishbone pipelined controls.
- wb_stall  out  1  constant 0.
- wb_ack  out  1  one-cycle acknowledge.
- wb_err  out  1  constant 0.

## Operation
- **Input stage.** All video inputs pass through one register stage. Edge detection compares the registered value with the previous registered value. "Asserted" follows SYNC_ACTIVE_LOW.
- **Line tracking.**
  - The 16-bit line counter clears to 0 on a vsync-deassert edge.
  - It increments (saturating) on each hsync-deassert edge.
  - A line is active when V_START <= line < V_START+V_ACTIVE.
- **Pixel tracking.**
  - The 16-bit cycle counter clears to 0 on each hsync-deassert edge and increments (saturating) every cycle.
  - A sample is taken when the line is active, cnt >= H_START, (cnt-H_START) mod CLKS_PER_PIXEL == 0, and pixel index < H_ACTIVE.
- **CRC.**
  - Polynomial 0x04C11DB7, non-reflected, init 0xFFFFFFFF, no final XOR.
  - Each sample shifts in the 12-bit word {r,g,b}, MSB first, in one cycle.
  - The running 32-bit pixel counter increments per sample.
- **Frame state machine.**
  - States: IDLE, ARMED, CAPTURE.
  - IDLE -> ARMED when ENABLE=1.
  - ARMED -> CAPTURE on a vsync-assert edge. Reset the running CRC and pixel counter.
  - CAPTURE -> CAPTURE on the next vsync-assert edge. This completes the frame:
    - latch CRC and pixel count;
    - FRAME_COUNT += 1 (32-bit wrap);
    - set DONE;
    - if DONE was already 1, set OVF;
    - reset the running CRC and pixel counter.
  - ENABLE=0 in any state -> IDLE. Any partial frame is discarded; latched registers are kept.
- **Registers** (word address):
  - 0 CTRL:
    - bit0 ENABLE, RW, updated only when sel[0]=1;
    - bit1 DONE, W1C;
    - bit2 OVF, W1C.
  - 1 CRC: last completed frame, RO.
  - 2 FRAME_COUNT: RO.
  - 3 PIXEL_COUNT: last completed frame, RO.
  - Writes to RO registers are ignored.
- **Simultaneous events.** If a frame completes in the same cycle as a W1C, the set wins: DONE=1, and OVF is evaluated against the pre-write DONE.

## Timing
- **Reset values:**
  - wb_dat_r = 0, wb_ack = 0, wb_stall = 0, wb_err = 0;
  - ENABLE = 0, DONE = 0, OVF = 0;
  - CRC = 0xFFFFFFFF, FRAME_COUNT = 0, PIXEL_COUNT = 0;
  - state IDLE, counters 0, input registers 0.
- **Reset mid-frame:** everything returns to the reset values immediately (asynchronous).
- **Wishbone:**
  - wb_ack is asserted exactly one cycle after each accepted cyc&stb.
  - wb_dat_r is valid in the ack cycle.
  - Back-to-back requests are acked on consecutive cycles.
  - A register write takes effect in the ack cycle.
  - A read returns the value from the cycle in which the request was accepted.
- **Capture latency:** 2 cycles from a pin edge to the counter update (input register + edge register). The CRC update lands in the cycle after the sample.
- **Frame latch:** visible on the bus 3 cycles after the vsync-assert pin edge.

## Test plan
1. **Reset/idle.** Parameters H_START=2, H_ACTIVE=4, V_START=1, V_ACTIVE=2, CLKS_PER_PIXEL=2. After reset, read all four registers -> 0x0, 0xFFFFFFFF, 0, 0.
2. **Single frame.** ENABLE=1; drive two full frames with all pixels 0xFFF. After the second vsync-assert edge: PIXEL_COUNT=8, FRAME_COUNT=1, DONE=1. CRC matches the bench model and is identical on the next frame.
3. **Sensitivity.** Flip one pixel to 0xFFE in a later frame -> CRC differs from scenario 2. Restoring the pixel restores the scenario 2 CRC.
4. **Overflow/W1C.** Leave DONE set across a frame -> OVF=1. Write CTRL=0x7 -> DONE=0, OVF=0, ENABLE=1. Write CTRL=0x3 in the frame-completion cycle -> DONE=1.
5. **Disable mid-frame.** Write ENABLE=0 mid-frame -> FRAME_COUNT unchanged. Re-enable -> the first complete frame afterwards counts, with PIXEL_COUNT=8.
6. **Blank window.** Set V_START beyond the frame height -> each frame latches PIXEL_COUNT=0 and CRC=0xFFFFFFFF. Assert rst_n low mid-frame -> all outputs return to the reset values.
